byte_deserializer: RTL and testbench

BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

---
 rtl/byte_deserializer_pkg.sv | 16 +
 rtl/bit_counter.sv | 28 ++
 rtl/byte_deserializer.sv | 104 ++++++++++
 tb/tb_byte_deserializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/byte_deserializer_pkg.sv
// Shared constants for the byte deserializer and its bench: FSM encodings
// and the bit-counter width helper.
package byte_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // A one-bit frame still needs a one-bit counter to hold a legal index.
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; it stops at
// TC_VALUE only because the owner stops enabling it there.
module bit_counter #(
  parameter int WIDTH    = 3,
  parameter int TC_VALUE = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == WIDTH'(TC_VALUE));

endmodule

// File: rtl/byte_deserializer.sv
// Strobe-paced UART-style deserializer: start 0, DATA_WIDTH data bits, stop 1.
// Good frames update d with a one-cycle load; bad stop bits pulse frame_err.
module byte_deserializer
  import byte_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_en,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  load,
  output logic                  frame_err,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CW = cnt_width(DATA_WIDTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_load;
  logic                  r_err;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_cnt_clear;
  logic                  w_cnt_en;
  logic                  w_tc;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_shift_next = {rx, r_shift[DATA_WIDTH-1:1]};
    end else begin : g_msb
      assign w_shift_next = {r_shift[DATA_WIDTH-2:0], rx};
    end
  endgenerate

  // Counter is held at its terminal value on the last data strobe so it never wraps.
  assign w_cnt_clear = bit_en && (r_state == ST_IDLE) && !rx;
  assign w_cnt_en    = bit_en && (r_state == ST_DATA) && !w_tc;

  bit_counter #(
    .WIDTH    (CW),
    .TC_VALUE (DATA_WIDTH - 1)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_d     <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      if (bit_en) begin
        case (r_state)
          ST_IDLE: begin
            if (!rx) begin
              r_state <= ST_DATA;
              r_busy  <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift <= w_shift_next;
            if (w_tc) r_state <= ST_STOP;
          end
          ST_STOP: begin
            if (rx) begin
              r_d    <= r_shift;
              r_load <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign d         = r_d;
  assign load      = r_load;
  assign frame_err = r_err;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_byte_deserializer.sv
// Bench for byte_deserializer: LSB-first and MSB-first instances share one
// serial stream; a monitor pops expected {is_load, d} entries on each pulse.
module tb_byte_deserializer;
  import byte_deserializer_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic bit_en;
  logic rx;
  always #5 clk = ~clk;

  logic [W-1:0] d_l, d_m;
  logic load_l, load_m, err_l, err_m, busy_l, busy_m;
  state_t st_l, st_m;

  byte_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .rx(rx),
    .d(d_l), .load(load_l), .frame_err(err_l), .busy(busy_l), .dbg_state(st_l)
  );

  byte_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .rx(rx),
    .d(d_m), .load(load_m), .frame_err(err_m), .busy(busy_m), .dbg_state(st_m)
  );

  // scoreboard: entries are {is_load, expected d}
  logic [W:0] exp_q_l[$];
  logic [W:0] exp_q_m[$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(input string tag, input logic ld, input logic er,
                         input logic [W-1:0] dv, inout logic [W:0] q[$]);
    logic [W:0] e;
    chk({"pulse_exclusive_", tag}, 32'(ld & er), 32'd0);
    if (ld || er) begin
      if (q.size() == 0) begin
        chk({"unexpected_pulse_", tag}, {30'd0, ld, er}, 32'd0);
      end else begin
        e = q.pop_front();
        chk({"pulse_kind_", tag}, 32'(ld), 32'(e[W]));
        chk({"d_at_pulse_", tag}, 32'(dv), 32'(e[W-1:0]));
      end
    end
  endtask

  // monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      mon_one("lsb", load_l, err_l, d_l, exp_q_l);
      mon_one("msb", load_m, err_m, d_m, exp_q_m);
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic strobe(input logic b, input int gap);
    rx     = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
    rx     = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic stop, input int max_gap);
    strobe(1'b0, $urandom_range(max_gap, 0));
    for (int i = 0; i < W; i++) strobe(word[i], $urandom_range(max_gap, 0));
    strobe(stop, 0);
  endtask

  task automatic settle();
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string tag, input logic [W-1:0] exp_l, input logic [W-1:0] exp_m);
    chk({"busy_lsb_", tag}, 32'(busy_l), 32'd0);
    chk({"busy_msb_", tag}, 32'(busy_m), 32'd0);
    chk({"state_lsb_", tag}, 32'(st_l), 32'(ST_IDLE));
    chk({"d_lsb_", tag}, 32'(d_l), 32'(exp_l));
    chk({"d_msb_", tag}, 32'(d_m), 32'(exp_m));
    chk({"queue_drained_lsb_", tag}, 32'(exp_q_l.size()), 32'd0);
    chk({"queue_drained_msb_", tag}, 32'(exp_q_m.size()), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    bit_en = 1'b0;
    rx     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_load", 32'(load_l | load_m), 32'd0);
    chk("reset_err", 32'(err_l | err_m), 32'd0);
    check_idle("reset", 8'h00, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // idle line: 20 strobes with rx high must not start a frame
    for (int i = 0; i < 20; i++) strobe(1'b1, $urandom_range(2, 0));
    settle();
    check_idle("idle", 8'h00, 8'h00);

    // good frame: rx 0,1,0,0,1,0,1,0,1,1
    exp_q_l.push_back({1'b1, 8'hA9});
    exp_q_m.push_back({1'b1, 8'h95});
    send_frame(8'hA9, 1'b1, 2);
    settle();
    check_idle("good_a9", 8'hA9, 8'h95);

    // bad stop bit: rx 0,1,1,1,0,0,0,0,0,0 leaves d untouched
    exp_q_l.push_back({1'b0, 8'hA9});
    exp_q_m.push_back({1'b0, 8'h95});
    send_frame(8'h07, 1'b0, 2);
    settle();
    check_idle("frame_err", 8'hA9, 8'h95);

    // back-to-back frames, start bit directly after the stop strobe
    exp_q_l.push_back({1'b1, 8'h07});
    exp_q_m.push_back({1'b1, 8'hE0});
    exp_q_l.push_back({1'b1, 8'h06});
    exp_q_m.push_back({1'b1, 8'h60});
    send_frame(8'h07, 1'b1, 3);
    chk("d_lsb_first_of_pair", 32'(d_l), 32'h07);
    chk("d_msb_first_of_pair", 32'(d_m), 32'hE0);
    send_frame(8'h06, 1'b1, 0);
    settle();
    check_idle("b2b", 8'h06, 8'h60);

    // reset mid-frame after four data bits of 0xFF
    strobe(1'b0, 1);
    for (int i = 0; i < 4; i++) strobe(1'b1, $urandom_range(1, 0));
    chk("busy_mid_frame", 32'(busy_l & busy_m), 32'd1);
    chk("state_mid_frame", 32'(st_l), 32'(ST_DATA));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_load", 32'(load_l | load_m | err_l | err_m), 32'd0);
    reset = 1'b0;
    check_idle("mid_reset", 8'h00, 8'h00);
    // remaining ones of the aborted frame plus a high stop bit: no frame may start
    for (int i = 0; i < 5; i++) strobe(1'b1, 1);
    settle();
    check_idle("post_reset_idle", 8'h00, 8'h00);

    exp_q_l.push_back({1'b1, 8'h06});
    exp_q_m.push_back({1'b1, 8'h60});
    send_frame(8'h06, 1'b1, 2);
    settle();
    check_idle("after_reset_06", 8'h06, 8'h60);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
